rr_select8: RTL and testbench
=============================

# rr_select8

Round-robin issue selector for eight request lines. It produces the registered 3-bit index that drives the select of the downstream 8:1 mux tree, along with its one-hot form. It holds each grant stable until the consumer accepts it with a valid/ready handshake, then rotates priority so that no requester starves. It sits between the ready-entry flags of an 8-entry buffer and the mux that reads out the chosen entry.

## Interface
- Parameters: none. Width is fixed at 8 requesters and a 3-bit index.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  8  per-entry request; bit i set means entry i is eligible
- flush  input  1  synchronous; drops any held grant
- grant_ready  input  1  consumer accepts the current grant at this edge
- grant_valid  output  1  a grant is held
- grant_addr  output  3  granted index; drives the mux8x1 addr
- grant_onehot  output  8  decode of grant_addr; 0 when grant_valid=0

## Operation
- State:
  - FSM with two states: IDLE (grant_valid=0) and HOLD (grant_valid=1).
  - Priority pointer ptr[2:0].
- Search rule: starting at index ptr, scan ptr, ptr+1, … mod 8 and select the first set bit of the masked request vector.
- IDLE:
  - The masked vector is req.
  - If any bit is set, load grant_addr and grant_onehot and go to HOLD.
  - Otherwise stay in IDLE.
- HOLD without handshake (grant_ready=0):
  - All outputs stay frozen.
  - req changes are ignored, including withdrawal of the granted bit.
- HOLD with handshake (grant_valid=1 and grant_ready=1 at an edge):
  - ptr <= grant_addr+1 (3-bit wrap, so 7 becomes 0).
  - Same edge, new search from the new ptr over req with bit grant_addr masked to 0. The requester cannot deassert in time, so it is excluded for this one edge only.
  - If a bit is found, load the new grant and stay in HOLD (back-to-back, 1 grant per cycle).
  - Otherwise go to IDLE.
- flush: highest synchronous priority.
  - Next state is IDLE, grant_valid <= 0, grant_addr and grant_onehot <= 0.
  - If a handshake occurs on the same edge, the transfer counts and ptr still advances; no new grant is loaded.
  - ptr is otherwise unchanged by flush.
- reset (asynchronous, any time, including mid-HOLD):
  - State goes to IDLE.
  - ptr=0, grant_valid=0, grant_addr=0, grant_onehot=0.
  - Outputs change without waiting for a clock edge.
- Invariant: grant_onehot == (grant_valid ? 1<<grant_addr : 0) in every cycle.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Latency: req set before edge k while IDLE gives grant_valid=1 from edge k.
- Handshake: a transfer occurs at each edge where grant_valid and grant_ready are both 1.
  - grant_ready may be held high while idle; it has no effect.
  - grant_addr must not change while grant_valid=1 and grant_ready=0.
- Sole persistent requester: it is granted every second cycle (valid 1,0,1,0) because of the one-edge mask.
- Reset release: the first grant can appear at the first edge after reset deasserts, provided req≠0.

## Test plan
- Async reset mid-HOLD:
  - Stimulus: grant 5 held with ready=0, then reset asserted between edges.
  - Required: grant_valid, grant_addr and grant_onehot go to 0 before the next edge; after release with req=8'h01, grant_addr=0.
- Round-robin alternation:
  - Stimulus: from reset, req=8'b1001_0000 and ready=1 held.
  - Required: grant_addr sequence is 4,7,4,7 on consecutive cycles, grant_valid stays 1, and grant_onehot alternates 8'h10/8'h80.
- Hold stability:
  - Stimulus: grant 2 issued, ready=0 for 5 cycles, req changed to 8'h01 during hold.
  - Required: grant_addr=2 and grant_onehot=8'h04 throughout. When ready is raised, the next grant is 0.
- Pointer wrap:
  - Stimulus: grant 5 accepted (ptr=6), then req=8'b0010_0001.
  - Required: next grant_addr=0, not 5.
- Flush with simultaneous handshake:
  - Stimulus: grant 3 held, flush=1 and ready=1 on the same edge, req=8'hFF.
  - Required: grant_valid=0 in the next cycle. The following grant (with flush=0) is 4, proving ptr advanced.
- Single requester:
  - Stimulus: req=8'h08 and ready=1 held.
  - Required: grant_valid toggles 1,0,1,0 with grant_addr=3 on each valid cycle.

Source files
------------

// File: rtl/rr_select8.sv
// Round-robin issue selector for eight requesters: holds a registered grant
// (index + one-hot) until a valid/ready transfer, then rotates priority.
module rr_select8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       flush,
  input  logic       grant_ready,
  output logic       grant_valid,
  output logic [2:0] grant_addr,
  output logic [7:0] grant_onehot,
  output logic       dbg_state
);

  // Handshake: a transfer happens at every rising edge where grant_valid and
  // grant_ready are both 1; grant_addr/grant_onehot are frozen while
  // grant_valid=1 and grant_ready=0, and grant_ready has no effect while idle.

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state;
  state_e     state_nxt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [2:0] addr_nxt;
  logic [7:0] onehot_nxt;
  logic [7:0] masked;
  logic       handshake;
  logic       hit;
  logic [2:0] hit_idx;
  logic [2:0] scan_idx;

  assign handshake = (state == HOLD) && grant_ready;
  assign ptr_nxt   = handshake ? grant_addr + 3'd1 : ptr;

  // The requester just served cannot drop its bit in time, so it is masked
  // out of the search for the transfer edge only.
  always_comb begin
    masked = req;
    if (handshake) begin
      masked[grant_addr] = 1'b0;
    end
  end

  // First set bit of the masked vector, scanning upward from the new pointer.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 3'd0;
    scan_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr_nxt + 3'(i);
      if (!hit && masked[scan_idx]) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  // grant_addr is parked at 0 whenever no grant is held.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = grant_addr;
    onehot_nxt = grant_onehot;
    if (flush) begin
      state_nxt  = IDLE;
      addr_nxt   = 3'd0;
      onehot_nxt = 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state_nxt  = HOLD;
            addr_nxt   = hit_idx;
            onehot_nxt = 8'h01 << hit_idx;
          end
        end
        HOLD: begin
          if (handshake) begin
            if (hit) begin
              state_nxt  = HOLD;
              addr_nxt   = hit_idx;
              onehot_nxt = 8'h01 << hit_idx;
            end else begin
              state_nxt  = IDLE;
              addr_nxt   = 3'd0;
              onehot_nxt = 8'h00;
            end
          end
        end
        default: begin
          state_nxt  = IDLE;
          addr_nxt   = 3'd0;
          onehot_nxt = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= 3'd0;
      grant_addr   <= 3'd0;
      grant_onehot <= 8'h00;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      grant_addr   <= addr_nxt;
      grant_onehot <= onehot_nxt;
    end
  end

  assign grant_valid = (state == HOLD);
  assign dbg_state   = state;

endmodule

// File: tb/tb_rr_select8.sv
// Self-checking bench for rr_select8: directed scenarios plus a random run,
// with expected grant words queued at stimulus time and popped after each edge.
module tb_rr_select8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       flush;
  logic       grant_ready;
  logic       grant_valid;
  logic [2:0] grant_addr;
  logic [7:0] grant_onehot;
  logic       dbg_state;

  logic [11:0] exp_q[$];
  int          total;
  int          bad;

  rr_select8 dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .flush        (flush),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_addr   (grant_addr),
    .grant_onehot (grant_onehot),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observable word {valid, addr, onehot}; addr is 0 when no grant.
  function automatic logic [11:0] gword(input logic v, input logic [2:0] a);
    logic [7:0] oh;
    oh = v ? (8'h01 << a) : 8'h00;
    return {v, (v ? a : 3'd0), oh};
  endfunction

  function automatic logic [11:0] obs();
    return {grant_valid, grant_addr, grant_onehot};
  endfunction

  // driver: pulse reset away from clock edges, leave inputs quiet
  task automatic apply_reset();
    req = 8'h00; flush = 1'b0; grant_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got, e;
    reset = 1'b1; req = 8'hFF; flush = 1'b0; grant_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(gword(1'b0, 3'd0));
      @(posedge clk); #1;
      got = obs(); e = exp_q.pop_front(); total++;
      if (got !== e || dbg_state !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h state=%b want=%h state=0", c, got, dbg_state, e);
      end
    end
    @(negedge clk);
    reset = 1'b0; req = 8'h00; grant_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0]  seq[6] = '{3'd4, 3'd7, 3'd4, 3'd7, 3'd4, 3'd7};
    logic [11:0] got, e;
    apply_reset();
    req = 8'b1001_0000; grant_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back(gword(1'b1, seq[c]));
      @(posedge clk); #1;
      got = obs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL round_robin cyc=%0d got=%h want=%h", c, got, e);
      end
    end
    grant_ready = 1'b0; req = 8'h00;
  endtask

  task automatic test_hold_stability();
    logic [11:0] got, e;
    apply_reset();
    req = 8'h04; grant_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) req = 8'h01;
      if (c == 6) grant_ready = 1'b1;
      exp_q.push_back(c == 6 ? gword(1'b1, 3'd0) : gword(1'b1, 3'd2));
      @(posedge clk); #1;
      got = obs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL hold_stability cyc=%0d got=%h want=%h", c, got, e);
      end
    end
    grant_ready = 1'b0; req = 8'h00;
  endtask

  task automatic test_pointer_wrap();
    logic [11:0] got, e;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin req = 8'b0010_0000; grant_ready = 1'b0; exp_q.push_back(gword(1'b1, 3'd5)); end
        1: begin req = 8'b0010_0001; grant_ready = 1'b1; exp_q.push_back(gword(1'b1, 3'd0)); end
        default: begin grant_ready = 1'b0; exp_q.push_back(gword(1'b1, 3'd0)); end
      endcase
      @(posedge clk); #1;
      got = obs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL pointer_wrap cyc=%0d got=%h want=%h", c, got, e);
      end
    end
    req = 8'h00;
  endtask

  task automatic test_flush();
    logic [11:0] got, e;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin req = 8'h08; flush = 1'b0; grant_ready = 1'b0; exp_q.push_back(gword(1'b1, 3'd3)); end
        1: begin req = 8'hFF; flush = 1'b1; grant_ready = 1'b1; exp_q.push_back(gword(1'b0, 3'd0)); end
        default: begin flush = 1'b0; grant_ready = 1'b0; exp_q.push_back(gword(1'b1, 3'd4)); end
      endcase
      @(posedge clk); #1;
      got = obs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL flush_handshake cyc=%0d got=%h want=%h", c, got, e);
      end
    end
    req = 8'h00;
  endtask

  task automatic test_single();
    logic [11:0] got, e;
    apply_reset();
    req = 8'h08; grant_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back(gword((c % 2) == 0, 3'd3));
      @(posedge clk); #1;
      got = obs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL single_req cyc=%0d got=%h want=%h", c, got, e);
      end
    end
    grant_ready = 1'b0; req = 8'h00;
  endtask

  task automatic test_async_reset();
    logic [11:0] got, e;
    apply_reset();
    req = 8'h20; grant_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(gword(1'b1, 3'd5));
      @(posedge clk); #1;
      got = obs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL async_pre cyc=%0d got=%h want=%h", c, got, e);
      end
    end
    #2;
    reset = 1'b1;
    exp_q.push_back(gword(1'b0, 3'd0));
    #1;
    got = obs(); e = exp_q.pop_front(); total++;
    if (got !== e || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL async_mid got=%h state=%b want=%h state=0", got, dbg_state, e);
    end
    #1;
    reset = 1'b0; req = 8'h01;
    exp_q.push_back(gword(1'b1, 3'd0));
    @(posedge clk); #1;
    got = obs(); e = exp_q.pop_front(); total++;
    if (got !== e) begin
      bad++;
      $display("FAIL async_release got=%h want=%h", got, e);
    end
    req = 8'h00;
  endtask

  // Random traffic against a behavioural reference of the arbitration rules.
  task automatic test_back_to_back();
    logic       m_valid;
    logic [2:0] m_addr;
    logic [2:0] m_ptr;
    logic [7:0] m_req;
    logic       hs;
    logic       found;
    logic [11:0] got, e;
    apply_reset();
    m_valid = 1'b0; m_addr = 3'd0; m_ptr = 3'd0;
    for (int c = 0; c < 300; c++) begin
      req         = 8'($urandom_range(0, 255));
      grant_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      hs = m_valid && grant_ready;
      m_req = req;
      if (hs) begin
        m_ptr = m_addr + 3'd1;
        m_req[m_addr] = 1'b0;
      end
      if (flush) begin
        m_valid = 1'b0; m_addr = 3'd0;
      end else if (!m_valid || hs) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (!found && m_req[(int'(m_ptr) + k) % 8]) begin
            found  = 1'b1;
            m_addr = 3'((int'(m_ptr) + k) % 8);
          end
        end
        m_valid = found;
        if (!found) m_addr = 3'd0;
      end
      exp_q.push_back(gword(m_valid, m_addr));
      @(posedge clk); #1;
      got = obs(); e = exp_q.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d req=%h rdy=%b fl=%b got=%h want=%h",
                 c, req, grant_ready, flush, got, e);
      end
    end
    req = 8'h00; flush = 1'b0; grant_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; req = 8'h00; flush = 1'b0; grant_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_hold_stability();
    test_pointer_wrap();
    test_flush();
    test_single();
    test_async_reset();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
